// File: rtl/subservient_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
// Ties go to the requester that was not granted last; reset favours A.
module subservient_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic last_q;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11)
            o_gnt = last_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_q <= 1'b1;
        else if (i_advance && |i_req)
            last_q <= o_gnt[1];
    end

endmodule

// File: rtl/subservient_ram_arbiter.sv
// Shares a byte-wide SRAM between two 32-bit Wishbone requesters,
// sequencing every granted word access as four byte cycles.
module subservient_ram_arbiter #(
    parameter int aw = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [aw-1:0] i_a_adr,
    input  logic [31:0]   i_a_dat,
    input  logic [3:0]    i_a_sel,
    input  logic          i_a_we,
    input  logic          i_a_stb,
    output logic [31:0]   o_a_rdt,
    output logic          o_a_ack,
    input  logic [aw-1:0] i_b_adr,
    input  logic [31:0]   i_b_dat,
    input  logic [3:0]    i_b_sel,
    input  logic          i_b_we,
    input  logic          i_b_stb,
    output logic [31:0]   o_b_rdt,
    output logic          o_b_ack,
    output logic [aw-1:0] o_sram_waddr,
    output logic [7:0]    o_sram_wdata,
    output logic          o_sram_wen,
    output logic [aw-1:0] o_sram_raddr,
    output logic          o_sram_ren,
    input  logic [7:0]    i_sram_rdata
);

    localparam logic [2:0] LAST_BYTE = 3'd3;
    localparam logic [2:0] RD_DRAIN  = 3'd4;

    typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_e;

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [aw-3:0]  wadr_q, wadr_d;
    logic [31:0]    dat_q, dat_d;
    logic [3:0]     sel_q, sel_d;
    logic           we_q, we_d;
    logic           own_q, own_d;
    logic [31:0]    rbuf_q, rbuf_d;
    logic [aw-1:0]  waddr_q, waddr_d, raddr_q, raddr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           wen_q, wen_d, ren_q, ren_d;
    logic           a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [31:0]    a_rdt_q, a_rdt_d, b_rdt_q, b_rdt_d;
    logic [1:0]     gnt;
    logic [1:0]     lane;
    logic           unused_adr;

    assign unused_adr = ^{i_a_adr[1:0], i_b_adr[1:0]};

    subservient_rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     ({i_b_stb, i_a_stb}),
        .i_advance (state_q == IDLE),
        .o_gnt     (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wadr_d  = wadr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        own_d   = own_q;
        rbuf_d  = rbuf_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        a_rdt_d = a_rdt_q;
        b_rdt_d = b_rdt_q;
        // Read data lags the issued address by one cycle
        lane    = cnt_q[1:0] - 2'd1;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    own_d   = gnt[1];
                    wadr_d  = gnt[1] ? i_b_adr[aw-1:2] : i_a_adr[aw-1:2];
                    dat_d   = gnt[1] ? i_b_dat : i_a_dat;
                    sel_d   = gnt[1] ? i_b_sel : i_a_sel;
                    we_d    = gnt[1] ? i_b_we : i_a_we;
                    cnt_d   = 3'd0;
                    state_d = we_d ? WR : RD;
                end
            end
            WR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_BYTE)
                    state_d = ACK;
            end
            RD: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0)
                    rbuf_d[{lane, 3'b000} +: 8] = i_sram_rdata;
                if (cnt_q == RD_DRAIN)
                    state_d = ACK;
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == WR) begin
            waddr_d = {wadr_d, cnt_d[1:0]};
            wdata_d = dat_d[{cnt_d[1:0], 3'b000} +: 8];
            wen_d   = sel_d[cnt_d[1:0]];
        end
        if (state_d == RD && !cnt_d[2]) begin
            raddr_d = {wadr_d, cnt_d[1:0]};
            ren_d   = 1'b1;
        end
        if (state_d == ACK) begin
            a_ack_d = !own_d;
            b_ack_d = own_d;
            if (!we_d && own_d)
                b_rdt_d = rbuf_d;
            if (!we_d && !own_d)
                a_rdt_d = rbuf_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wadr_q  <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            own_q   <= 1'b0;
            rbuf_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            raddr_q <= '0;
            ren_q   <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            a_rdt_q <= '0;
            b_rdt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wadr_q  <= wadr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            own_q   <= own_d;
            rbuf_q  <= rbuf_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            raddr_q <= raddr_d;
            ren_q   <= ren_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            a_rdt_q <= a_rdt_d;
            b_rdt_q <= b_rdt_d;
        end
    end

    assign o_sram_waddr = waddr_q;
    assign o_sram_wdata = wdata_q;
    assign o_sram_wen   = wen_q;
    assign o_sram_raddr = raddr_q;
    assign o_sram_ren   = ren_q;
    assign o_a_ack      = a_ack_q;
    assign o_b_ack      = b_ack_q;
    assign o_a_rdt      = a_rdt_q;
    assign o_b_rdt      = b_rdt_q;

endmodule

// File: tb/tb_subservient_ram_arbiter.sv
// Bench for subservient_ram_arbiter: transaction-level model with
// latency rules, a byte memory image and round-robin ownership.
module tb_subservient_ram_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] a_adr, b_adr;
    logic [31:0]   a_dat, b_dat;
    logic [3:0]    a_sel, b_sel;
    logic          a_we, b_we, a_stb, b_stb;
    logic [31:0]   a_rdt, b_rdt;
    logic          a_ack, b_ack;
    logic [AW-1:0] waddr, raddr;
    logic [7:0]    wdata;
    logic [7:0]    rdata = 8'h00;
    logic          wen, ren;

    always #5 clk = ~clk;

    subservient_ram_arbiter #(.aw(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_a_adr      (a_adr),
        .i_a_dat      (a_dat),
        .i_a_sel      (a_sel),
        .i_a_we       (a_we),
        .i_a_stb      (a_stb),
        .o_a_rdt      (a_rdt),
        .o_a_ack      (a_ack),
        .i_b_adr      (b_adr),
        .i_b_dat      (b_dat),
        .i_b_sel      (b_sel),
        .i_b_we       (b_we),
        .i_b_stb      (b_stb),
        .o_b_rdt      (b_rdt),
        .o_b_ack      (b_ack),
        .o_sram_waddr (waddr),
        .o_sram_wdata (wdata),
        .o_sram_wen   (wen),
        .o_sram_raddr (raddr),
        .o_sram_ren   (ren),
        .i_sram_rdata (rdata)
    );

    logic [7:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (wen) sram[waddr] <= wdata;
        if (ren) rdata <= sram[raddr];
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0]    mem_m [0:(1<<AW)-1];
    int            cyc = 0;
    int            gcyc = 0;
    int            lat = 0;
    bit            busy = 0;
    bit            own = 0;
    bit            last_b = 1;
    logic          m_we = 0;
    logic [3:0]    m_sel = 0;
    logic [AW-3:0] m_wadr = 0;
    logic [31:0]   m_dat = 0;
    logic [31:0]   m_rd = 0;
    logic [31:0]   exp_rdt_a = 0, exp_rdt_b = 0;
    bit            pend_a = 0, pend_b = 0;
    bit            ea = 0, eb = 0;
    int            auto_pct = 0;
    bit            drops = 0;
    bit            ackq[$];

    task automatic model_edge();
        bit tb;
        logic [AW-1:0] ba;
        if (!rst_n) return;
        if (busy) begin
            if (cyc == gcyc + lat) busy = 0;
            return;
        end
        if (!(a_stb || b_stb)) return;
        tb = b_stb && (!a_stb || !last_b);
        own = tb;
        last_b = tb;
        busy = 1;
        gcyc = cyc;
        m_we = tb ? b_we : a_we;
        m_sel = tb ? b_sel : a_sel;
        m_dat = tb ? b_dat : a_dat;
        m_wadr = tb ? b_adr[AW-1:2] : a_adr[AW-1:2];
        lat = m_we ? 5 : 6;
        for (int i = 0; i < 4; i++) begin
            ba = {m_wadr, 2'(i)};
            if (m_we && m_sel[i]) mem_m[ba] = m_dat[8*i +: 8];
            if (!m_we) m_rd[8*i +: 8] = mem_m[ba];
        end
    endtask

    task automatic check_outputs();
        int k;
        bit ew, er;
        ea = busy && !own && cyc == gcyc + lat - 1;
        eb = busy && own && cyc == gcyc + lat - 1;
        if (ea && !m_we) exp_rdt_a = m_rd;
        if (eb && !m_we) exp_rdt_b = m_rd;
        if (ea) ackq.push_back(1'b0);
        if (eb) ackq.push_back(1'b1);
        chk("a_ack", a_ack, ea);
        chk("b_ack", b_ack, eb);
        chk("a_rdt", a_rdt, exp_rdt_a);
        chk("b_rdt", b_rdt, exp_rdt_b);
        k = cyc - gcyc;
        ew = busy && m_we && k >= 0 && k <= 3 && m_sel[k & 3];
        er = busy && !m_we && k >= 0 && k <= 3;
        chk("wen", wen, ew);
        chk("ren", ren, er);
        if (ew) begin
            chk("waddr", waddr, {m_wadr, 2'(k)});
            chk("wdata", wdata, m_dat[8*(k & 3) +: 8]);
        end
        if (er) chk("raddr", raddr, {m_wadr, 2'(k)});
    endtask

    task automatic issue(input bit who, input bit we, input logic [AW-1:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (who) begin
            b_we = we; b_adr = adr; b_dat = dat; b_sel = sel;
            b_stb = 1; pend_b = 1;
        end else begin
            a_we = we; a_adr = adr; a_dat = dat; a_sel = sel;
            a_stb = 1; pend_a = 1;
        end
    endtask

    task automatic issue_rand(input bit who);
        logic [AW-1:0] adr;
        adr = {5'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        issue(who, 1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom));
    endtask

    task automatic update_masters();
        if (ea) begin pend_a = 0; a_stb = 0; end
        if (eb) begin pend_b = 0; b_stb = 0; end
        if (drops && busy && !own && pend_a && $urandom_range(0, 7) == 0)
            a_stb = 0;
        if (drops && busy && own && pend_b && $urandom_range(0, 7) == 0)
            b_stb = 0;
        if (!pend_a && $urandom_range(0, 99) < auto_pct) issue_rand(0);
        if (!pend_b && $urandom_range(0, 99) < auto_pct) issue_rand(1);
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_outputs();
        update_masters();
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while ((pend_a || pend_b || busy) && n < bound) begin
            cycle();
            n++;
        end
        chk("idle_wait", {pend_a, pend_b, busy}, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = 8'h00;
            mem_m[i] = 8'h00;
        end
        a_adr = 0; a_dat = 0; a_sel = 0; a_we = 0; a_stb = 0;
        b_adr = 0; b_dat = 0; b_sel = 0; b_we = 0; b_stb = 0;

        repeat (3) cycle();
        chk("rst_waddr", waddr, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_wdata", wdata, 0);
        rst_n = 1;
        cycle();

        issue(0, 1, 10'h010, 32'hDDCCBBAA, 4'hF);
        wait_done(20);
        issue(0, 0, 10'h010, 32'h0, 4'h0);
        wait_done(20);
        chk("rd_a_word", a_rdt, 32'hDDCCBBAA);

        issue(1, 1, 10'h020, 32'h44332211, 4'h5);
        wait_done(20);
        issue(1, 0, 10'h020, 32'h0, 4'hF);
        wait_done(20);
        chk("rd_b_word", b_rdt, 32'h00330011);

        ackq.delete();
        issue_rand(0);
        issue_rand(1);
        auto_pct = 100;
        repeat (30) cycle();
        auto_pct = 0;
        wait_done(40);
        chk("alt_count", ackq.size() >= 4, 1);
        for (int i = 1; i < ackq.size(); i++)
            chk("alternate", ackq[i], !ackq[i-1]);

        issue(0, 1, 10'h0A4, 32'h87654321, 4'hF);
        n = 0;
        while (!(busy && cyc == gcyc + 2) && n < 20) begin
            cycle();
            n++;
        end
        #2 rst_n = 0;
        #1;
        chk("arst_wen", wen, 0);
        chk("arst_ren", ren, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_wdata", wdata, 0);
        chk("arst_a_ack", a_ack, 0);
        chk("arst_a_rdt", a_rdt, 0);
        chk("arst_b_rdt", b_rdt, 0);
        busy = 0; last_b = 1; exp_rdt_a = 0; exp_rdt_b = 0;
        pend_a = 0; pend_b = 0; a_stb = 0; b_stb = 0;
        repeat (2) cycle();
        rst_n = 1;
        repeat (2) cycle();
        issue(0, 1, 10'h0A4, 32'h87654321, 4'hF);
        wait_done(20);
        issue(0, 0, 10'h0A4, 32'h0, 4'h0);
        wait_done(20);
        chk("rst_rewrite", a_rdt, 32'h87654321);

        ackq.delete();
        issue(0, 0, 10'h0A4, 32'h0, 4'h0);
        cycle();
        issue(1, 1, 10'h0A8, 32'hCAFEF00D, 4'hF);
        a_stb = 0;
        wait_done(40);
        chk("drop_n", ackq.size(), 2);
        if (ackq.size() == 2) begin
            chk("drop_first", ackq[0], 0);
            chk("drop_next", ackq[1], 1);
        end
        chk("drop_rdt", a_rdt, 32'h87654321);

        drops = 1;
        auto_pct = 30;
        repeat (400) cycle();
        auto_pct = 0;
        wait_done(60);
        drops = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/subservient_ram_arbiter.md
Name: subservient_ram_arbiter

Overview:
- Shares one byte-wide single-port-style SRAM (separate read/write address, 1-cycle registered read latency) between two 32-bit Wishbone-classic requesters, A and B, e.g. CPU and debug/loader.
- Each granted 32-bit access is sequenced as four byte cycles on the SRAM interface.
- Arbitration is round-robin, one whole transaction per grant.
- Sits between the bus masters and the generic SRAM wrapper.

Parameters:
- aw, 10, SRAM byte-address width; word address is aw-2 bits.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_a_adr  in  aw  requester A byte address; bits [1:0] ignored
- i_a_dat  in  32  A write data
- i_a_sel  in  4  A byte enables (bit i = byte i, little-endian)
- i_a_we  in  1  A write (1) / read (0)
- i_a_stb  in  1  A request, held until ack
- o_a_rdt  out  32  A read data, valid with o_a_ack
- o_a_ack  out  1  A single-cycle completion
- i_b_adr, i_b_dat, i_b_sel, i_b_we, i_b_stb, o_b_rdt, o_b_ack: same as A, for B
- o_sram_waddr  out  aw  SRAM write address
- o_sram_wdata  out  8  SRAM write data
- o_sram_wen  out  1  SRAM write enable
- o_sram_raddr  out  aw  SRAM read address
- o_sram_ren  out  1  SRAM read enable
- i_sram_rdata  in  8  SRAM read data, valid the cycle after ren

Behaviour:
- Reset (async assert, sync release): state IDLE, last-grant = B (so A wins first tie), o_*_ack=0, o_*_rdt=0, o_sram_wen=0, o_sram_ren=0, addresses=0, wdata=0.
- All SRAM outputs are registered.
- States: IDLE, WR, RD, ACK.
- IDLE:
  - If no stb, stay.
  - If one stb, grant it.
  - If both, grant the requester not granted last.
  - On grant: latch word address, data, sel and we; set byte counter cnt=0; go to WR if we, else RD. Update last-grant.
- Byte address on SRAM = {word_adr, cnt[1:0]}.
- WR: 4 cycles, cnt 0..3.
  - o_sram_waddr = {word_adr, cnt}, o_sram_wdata = dat[8*cnt+7:8*cnt], o_sram_wen = sel[cnt].
  - sel=0000 still takes 4 cycles and writes nothing.
  - After cnt=3, go to ACK.
- RD: cnt 0..3 issues o_sram_ren=1 with o_sram_raddr = {word_adr, cnt}.
  - i_sram_rdata is captured one cycle after each issue into byte lane cnt_d (delayed counter).
  - A 5th RD cycle (ren=0) captures byte 3, then go to ACK.
  - sel is ignored on reads; all 4 bytes are always returned.
- ACK: exactly one cycle.
  - o_x_ack=1 for the granted requester only, with o_x_rdt driving the assembled word (reads; for writes rdt holds its previous value).
  - stb sampled in the ACK cycle is ignored; the next state is always IDLE, where arbitration is re-evaluated.
- Latency from the stb-sampled grant edge: write ack 5 cycles later, read ack 6 cycles later. Minimum back-to-back period: write 6, read 7 cycles.
- wen and ren are never asserted in the same cycle. The SRAM is idle in IDLE and ACK.
- A requester dropping stb mid-transaction is a protocol violation. The transaction completes and ack is still issued.
- Address changes while stb is held are ignored (latched at grant).
- Reset asserted mid-transaction: immediate return to reset values. No ack; a partial write may have been committed.
- Word address wrap: none needed; cnt only spans the 4 bytes of one aligned word.

Decomposition:
- No shared package; the state encodings and the byte count (4) are module-local localparams.
- One natural sub-module: subservient_rr_arb2. It holds the 2-way round-robin grant with last-grant register, async active-low reset, inputs req[1:0] and advance, output one-hot gnt.

Test Plan:
- Reset then A write adr=0x010, dat=0xDDCCBBAA, sel=1111 -> wen pulses at waddr 0x010..0x013 with AA,BB,CC,DD on consecutive cycles; o_a_ack one cycle 5 cycles after grant; o_b_ack stays 0.
- A read adr=0x010 after the above -> ren at raddr 0x010..0x013; o_a_rdt=0xDDCCBBAA with ack 6 cycles after grant.
- B write adr=0x020, dat=0x44332211, sel=0101 -> wen=1 only at 0x020 (11) and 0x022 (33); subsequent read returns 0x00330011 when RAM was preloaded with zeros.
- A and B stb together, both held continuously for 4 transactions -> grants alternate A,B,A,B; each ack is routed only to its owner.
- Assert i_rst_n low during WR cnt=2 of an A write -> all outputs 0 asynchronously; after release, no ack; A's re-request is served normally.
- A stb drops after grant of a read -> full 4-byte sequence runs; o_a_ack still pulses once; the next IDLE grants B if it is requesting.
